// File: rtl/anu_fifo_pkg.sv
// Shared definitions for the anu_fifo_sync buffering stage.
//   clog2_safe  : ceil(log2(n)), never below 1, so a pointer always has at least one bit.
//   cnt_width   : bits needed to hold an occupancy of 0..depth inclusive.
//   DEFAULT_*   : widths for the default 16-entry configuration.
package anu_fifo_pkg;

  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_PTR_W = clog2_safe(DEFAULT_DEPTH);
  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/anu_fifo_sync_if.sv
// Handshake/status bundle between a FIFO client and anu_fifo_sync.
//   master : the client; drives wr_en, wr_data, rd_en, clr_err and observes the rest.
//   slave  : the FIFO; drives rd_data, rd_valid, full, empty, almost_full, almost_empty,
//            count, overflow and underflow.
interface anu_fifo_sync_if
  import anu_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/anu_fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module anu_fifo_mem
  import anu_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = clog2_safe(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/anu_fifo_sync.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable registered or first-word-fall-through read.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : slave side of anu_fifo_sync_if
//         in  wr_en/wr_data  write request and data
//         in  rd_en          read/pop request
//         in  clr_err        clears the sticky error flags
//         out rd_data/rd_valid, full, empty, almost_full, almost_empty, count,
//             overflow, underflow
module anu_fifo_sync
  import anu_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  parameter bit          FWFT      = 1'b0
) (
  input logic            clk,
  input logic            rst,
  anu_fifo_sync_if.slave bus
);

  localparam int unsigned PTR_W = clog2_safe(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_TH_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_TH_C = CNT_W'(AEMPTY_TH);

  // Elaboration-time parameter sanity checks.
  if (DATA_W < 1) begin : gen_bad_data_w
    $error("anu_fifo_sync: DATA_W must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("anu_fifo_sync: DEPTH must be a power of two and at least 2");
  end
  if (!((AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH))) begin : gen_bad_thresholds
    $error("anu_fifo_sync: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty;
  logic              rd_acc, wr_acc;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Status decodes look only at the registered count, never at this cycle's requests.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
  // The converse does not hold: a write into an empty FIFO cannot be read back the same cycle.
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);

  // Suppress the write while in reset so an in-flight write leaves no trace.
  assign mem_we = wr_acc && !rst;

  anu_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting beats clearing when both happen in the same cycle.
    overflow_d  = (bus.wr_en && !wr_acc) || (overflow_q && !bus.clr_err);
    underflow_d = (bus.rd_en && !rd_acc) || (underflow_q && !bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT) begin : gen_fwft
    // Head entry is presented combinationally; rd_acc just advances past it.
    assign bus.rd_data  = mem_rdata;
    assign bus.rd_valid = !empty;
  end else begin : gen_registered
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem_rdata;
        end
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_TH_C);
  assign bus.almost_empty = (count_q <= AEMPTY_TH_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_anu_fifo_sync.sv
// Drives a registered-read and a first-word-fall-through FIFO with identical stimulus and
// checks both against a queue-based model every cycle, plus literal spot checks.
module tb_anu_fifo_sync;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEP   = 16;
  localparam int unsigned AF_TH = DEP - 2;
  localparam int unsigned AE_TH = 2;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  anu_fifo_sync_if #(.DATA_W(DW), .DEPTH(DEP)) if0 ();
  anu_fifo_sync_if #(.DATA_W(DW), .DEPTH(DEP)) if1 ();

  assign if0.wr_en   = wr_en;
  assign if0.wr_data = wr_data;
  assign if0.rd_en   = rd_en;
  assign if0.clr_err = clr_err;
  assign if1.wr_en   = wr_en;
  assign if1.wr_data = wr_data;
  assign if1.rd_en   = rd_en;
  assign if1.clr_err = clr_err;

  anu_fifo_sync #(
    .DATA_W    (DW),
    .DEPTH     (DEP),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH),
    .FWFT      (1'b0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  anu_fifo_sync #(
    .DATA_W    (DW),
    .DEPTH     (DEP),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH),
    .FWFT      (1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags and registered-read output as plain bits.
  logic [DW-1:0] q [$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            m_rv0 = 1'b0;
  logic [DW-1:0] m_rd0 = '0;

  always @(posedge clk) begin
    bit r_ok, w_ok, was_empty, was_full;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv0 = 1'b0;
      m_rd0 = '0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEP);
      r_ok = rd_en && !was_empty;
      w_ok = wr_en && (!was_full || r_ok);
      m_rv0 = r_ok;
      if (r_ok) m_rd0 = q.pop_front();
      if (w_ok) q.push_back(wr_data);
      if (wr_en && !w_ok) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
      if (rd_en && !r_ok) m_udf = 1'b1;
      else if (clr_err)   m_udf = 1'b0;
    end
  end

  // Compare process: outputs depend only on registered state, so mid-cycle is stable.
  always @(negedge clk) begin
    int unsigned n;
    if (chk_en) begin
      n = q.size();
      check("count0", 32'(if0.count), n);
      check("count1", 32'(if1.count), n);
      check("full0", 32'(if0.full), 32'(n == DEP));
      check("full1", 32'(if1.full), 32'(n == DEP));
      check("empty0", 32'(if0.empty), 32'(n == 0));
      check("empty1", 32'(if1.empty), 32'(n == 0));
      check("almost_full0", 32'(if0.almost_full), 32'(n >= AF_TH));
      check("almost_full1", 32'(if1.almost_full), 32'(n >= AF_TH));
      check("almost_empty0", 32'(if0.almost_empty), 32'(n <= AE_TH));
      check("almost_empty1", 32'(if1.almost_empty), 32'(n <= AE_TH));
      check("overflow0", 32'(if0.overflow), 32'(m_ovf));
      check("overflow1", 32'(if1.overflow), 32'(m_ovf));
      check("underflow0", 32'(if0.underflow), 32'(m_udf));
      check("underflow1", 32'(if1.underflow), 32'(m_udf));
      check("rd_valid0", 32'(if0.rd_valid), 32'(m_rv0));
      check("rd_data0", 32'(if0.rd_data), 32'(m_rd0));
      check("rd_valid1", 32'(if1.rd_valid), 32'(n != 0));
      if (n != 0) check("rd_data1", 32'(if1.rd_data), 32'(q[0]));
    end
  end

  // Apply one cycle of stimulus; returns 1 time unit after the active edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                       input logic ce, input logic r);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    clr_err = ce;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] wd;
    int            guard;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst     = 1'b1;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk_en = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    check("rst_empty", 32'(if0.empty), 1);
    check("rst_almost_empty", 32'(if0.almost_empty), 1);
    check("rst_count", 32'(if0.count), 0);
    check("rst_rd_valid", 32'(if0.rd_valid), 0);
    check("rst_rd_data", 32'(if0.rd_data), 0);
    check("rst_overflow", 32'(if0.overflow), 0);
    check("rst_underflow", 32'(if1.underflow), 0);

    // Fill with 0x00..0x0F, then read back in order.
    for (int i = 0; i < 16; i++) begin
      cycle(1, 8'(i), 0, 0, 0);
      if (i == 12) check("afull_at_13", 32'(if0.almost_full), 0);
      if (i == 13) check("afull_at_14", 32'(if0.almost_full), 1);
      if (i == 14) check("full_at_15", 32'(if0.full), 0);
      if (i == 15) check("full_at_16", 32'(if0.full), 1);
    end
    check("count_full", 32'(if0.count), 16);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 0, 0);
      check("seq_rd_valid", 32'(if0.rd_valid), 1);
      check("seq_rd_data", 32'(if0.rd_data), 32'(i));
    end
    cycle(0, 0, 0, 0, 0);
    check("seq_empty", 32'(if0.empty), 1);
    check("seq_rd_valid_drop", 32'(if0.rd_valid), 0);

    // Write to full with concurrent read, then rejected write, then clear.
    for (int i = 0; i < 16; i++) cycle(1, 8'(16 + i), 0, 0, 0);
    cycle(1, 8'hAA, 1, 0, 0);
    check("full_rw_count", 32'(if0.count), 16);
    check("full_rw_ovf", 32'(if0.overflow), 0);
    check("full_rw_data", 32'(if0.rd_data), 32'h10);
    cycle(1, 8'hAA, 0, 0, 0);
    check("ovf_set", 32'(if0.overflow), 1);
    check("ovf_count", 32'(if0.count), 16);
    cycle(0, 0, 0, 1, 0);
    check("ovf_clear", 32'(if0.overflow), 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0);
    check("drain_last_aa", 32'(if0.rd_data), 32'hAA);
    check("drain_empty", 32'(if0.empty), 1);

    // Read on empty with concurrent write.
    cycle(1, 8'h55, 1, 0, 0);
    check("udf_set", 32'(if0.underflow), 1);
    check("udf_count", 32'(if0.count), 1);
    check("udf_fwft_head", 32'(if1.rd_data), 32'h55);
    cycle(0, 0, 1, 1, 0);
    check("udf_read_data", 32'(if0.rd_data), 32'h55);
    check("udf_cleared", 32'(if0.underflow), 0);

    // Fall-through presentation.
    cycle(1, 8'h3C, 0, 0, 0);
    check("fwft_valid", 32'(if1.rd_valid), 1);
    check("fwft_data", 32'(if1.rd_data), 32'h3C);
    cycle(0, 0, 1, 0, 0);
    check("fwft_pop_valid", 32'(if1.rd_valid), 0);

    // Bring occupancy to 8 and stream with simultaneous read/write across pointer wrap.
    guard = 0;
    while (q.size() < 8 && guard < 32) begin
      cycle(1, 8'($urandom), 0, 0, 0);
      guard++;
    end
    check("fill_to_8", 32'(q.size()), 8);
    for (int i = 0; i < 40; i++) cycle(1, 8'($urandom), 1, 0, 0);
    check("stream_count", 32'(if0.count), 8);
    check("stream_count_fwft", 32'(if1.count), 8);

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 300; i++) begin
      wd = 8'($urandom);
      if (i == 120) begin
        cycle(1, wd, 1, 0, 1);
        check("mid_rst_count", 32'(if0.count), 0);
        check("mid_rst_empty", 32'(if1.empty), 1);
        check("mid_rst_rd_valid", 32'(if0.rd_valid), 0);
        check("mid_rst_rd_data", 32'(if0.rd_data), 0);
        check("mid_rst_ovf", 32'(if0.overflow), 0);
        check("mid_rst_udf", 32'(if0.underflow), 0);
      end else begin
        cycle(1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), 0);
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anu_fifo_sync.md
# anu_fifo_sync

Parametrised single-clock FIFO: the buffering stage between the byte-wide input pins and downstream consumers in the tt_um_anu_fifo_cd design. It generalises the fixed 8-bit datapath to configurable width and depth and adds:
- occupancy count and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- DATA_W, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AFULL_TH, DEPTH-2: almost_full asserted when count ≥ AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserted when count ≤ AEMPTY_TH.
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read/pop request.
- clr_err  in  1  clears the sticky error flags.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH × DATA_W register array. Memory is not reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0.
- count is a separate registered counter:
  - +1 on a write only;
  - −1 on a read only;
  - unchanged when both are accepted in the same cycle.
- rd_acc = rd_en && !empty. A write into an empty FIFO in the same cycle does not make the read acceptable.
- wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count only; they never depend on the current cycle's inputs.
- Error flags:
  - overflow is set on wr_en && !wr_acc;
  - underflow is set on rd_en && !rd_acc;
  - both hold until clr_err or rst;
  - if a set condition and clr_err occur in the same cycle, set wins.
- FWFT=0:
  - on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1;
  - otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1:
  - rd_data = mem[rd_ptr], combinational;
  - rd_valid = !empty;
  - rd_acc pops the head entry.
- Reset takes effect on the next clock edge; any in-flight read or write in that cycle is discarded. After reset:
  - wr_ptr = rd_ptr = 0, count = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0;
  - rd_valid = 0, rd_data = 0 (FWFT=0), overflow = underflow = 0.

## Timing
- Write latency (FWFT=1): an entry written at edge N is visible on rd_data/rd_valid after edge N.
- Write latency (count and flags): count and all flags update at the same edge as the access.
- Read latency, FWFT=0: 1 cycle. rd_en at edge N gives rd_valid/rd_data valid for the cycle after edge N.
- Read latency, FWFT=1: 0 cycles. The head entry is presented whenever the FIFO is non-empty.
- Sustained simultaneous read and write gives 1 entry/cycle throughput at any occupancy from 1 to DEPTH.
- No combinational path from wr_en or rd_en to full, empty or count.

## Structure
- Package anu_fifo_pkg holds:
  - function clog2_safe;
  - localparams for pointer width and count width derived from DEPTH.
- Sub-module anu_fifo_mem: a DEPTH × DATA_W register file with one synchronous write port and one asynchronous read port. The top level owns the pointers, count, flags and the FWFT output mux.
- Elaboration-time checks:
  - DEPTH is a power of two and ≥2;
  - AEMPTY_TH < AFULL_TH ≤ DEPTH.

## Test plan
- Reset, then 3 idle cycles → empty=1, almost_empty=1, count=0, rd_valid=0, overflow=underflow=0.
- DEPTH=16, FWFT=0: write 0x00..0x0F, then read 16 times → full=1 after the 16th write; almost_full=1 from count=14; data returns 0x00..0x0F in order, each one cycle after rd_en; empty=1 at the end.
- Fill to full, write 0xAA with rd_en=1 → write accepted, count stays 16, no overflow. Repeat the write with rd_en=0 → overflow=1, count=16, 0xAA not stored. clr_err → overflow=0.
- Empty FIFO, rd_en=1 with wr_en=1 and wr_data=0x55 → underflow=1, count=1; the next read returns 0x55.
- FWFT=1: write 0x3C to empty → next cycle rd_valid=1 and rd_data=0x3C with no rd_en; pop → rd_valid=0 the following cycle.
- Pointer wrap and mid-operation reset:
  - 40 cycles of random simultaneous read/write at count≈8 → scoreboard matches and count stays constant;
  - assert rst mid-stream → all outputs at reset values after the edge; subsequent data is uncorrupted.
